// File: rtl/onchip_memory_bist_master.sv
// onchip_memory_bist_master: Avalon-MM initiator that fills the on-chip
// memory with a seed+address pattern and/or reads it back and checks it.
// Every read carries its expected word and address through a
// READ_LATENCY-deep tag pipeline. The compare fires when the tag reaches
// the end of that pipeline.
module onchip_memory_bist_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 5120,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable,
    output logic                    avm_chipselect,
    output logic                    avm_write,
    output logic [DATA_WIDTH-1:0]   avm_writedata,
    output logic                    avm_clken,
    input  logic [DATA_WIDTH-1:0]   avm_readdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);
    localparam logic [1:0]            MODE_VERIFY = 2'b01;
    localparam logic [1:0]            MODE_BOTH   = 2'b10;
    localparam logic [1:0]            MODE_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_GAP,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
    } rd_tag_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            drain_q, drain_d;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  pass_q, pass_d;
    rd_tag_t               rd_pipe_q [READ_LATENCY];

    logic                  accept;
    logic                  issue_rd;
    logic                  mismatch;
    logic [DATA_WIDTH-1:0] pattern;
    rd_tag_t               rd_ret;

    // Start is honoured only when idle and the mode is not reserved.
    always_comb begin
        accept   = (state_q == S_IDLE) && start && (mode != MODE_RSVD);
        issue_rd = (state_q == S_VERIFY);
        pattern  = (state_q == S_IDLE) ? '0 : seed_q + DATA_WIDTH'(addr_q);
        rd_ret   = rd_pipe_q[READ_LATENCY-1];
        mismatch = rd_ret.vld && (avm_readdata != rd_ret.exp);
    end

    // State, address counter and drain counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: sweep addresses in FILL and VERIFY, then retire reads in DRAIN.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = '0;
                    state_d = (mode == MODE_VERIFY) ? S_VERIFY : S_FILL;
                end
            end
            S_FILL: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = (mode_q == MODE_BOTH) ? S_GAP : S_DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_VERIFY;
            end
            S_VERIFY: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The run configuration is captured at the start so that mid-run input changes have no effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= '0;
            seed_q <= '0;
        end else if (accept) begin
            mode_q <= mode;
            seed_q <= seed;
        end
    end

    // Read tag pipeline: the expected word and address follow each read to its return cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            rd_pipe_q[0] <= '{vld: issue_rd, exp: pattern, addr: addr_q};
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    // Result update: clear on start, count mismatches (saturating), and latch the first failing address.
    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        if (accept) begin
            err_d   = '0;
            first_d = '0;
            pass_d  = 1'b0;
        end else if (mismatch) begin
            if (err_q != '1) begin
                err_d = err_q + 16'd1;
            end
            if (err_q == '0) begin
                first_d = rd_ret.addr;
            end
        end
        // The final compare retires in the last DRAIN cycle, so err_d is used here rather than err_q.
        if ((state_q == S_DRAIN) && (drain_q == DRAIN_LAST)) begin
            pass_d = (err_d == '0);
        end
    end

    // Result registers hold until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    // Bus and status outputs decoded from state, so they drop together with an asynchronous reset.
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        avm_chipselect = (state_q == S_FILL) || (state_q == S_VERIFY);
        avm_write      = (state_q == S_FILL);
        avm_address    = avm_chipselect ? addr_q : '0;
        avm_byteenable = avm_chipselect ? '1 : '0;
        avm_writedata  = (state_q == S_FILL) ? pattern : '0;
        avm_clken      = 1'b1;
        pass           = pass_q;
        err_count      = err_q;
        first_err_addr = first_q;
    end

endmodule

// File: tb/tb_onchip_memory_bist_master.sv
// Bench for onchip_memory_bist_master: directed cases plus randomized runs.
// The expectations come from a simple model of the pattern and the slave memory image.
module tb_onchip_memory_bist_master;

    localparam int DW = 32;
    localparam int AW = 13;
    localparam int D  = 8;
    localparam int L  = 1;
    localparam int L3 = 3;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start3;
    logic [1:0]  mode_i, mode3;
    logic [31:0] seed_i, seed3;

    logic          busy, done, pass, cs, we, clken;
    logic [15:0]   errc;
    logic [AW-1:0] ferr, addr;
    logic [3:0]    be;
    logic [31:0]   wdata, rdata;

    logic          busy3, done3, pass3, cs3, we3, clken3;
    logic [15:0]   errc3;
    logic [AW-1:0] ferr3, addr3;
    logic [3:0]    be3;
    logic [31:0]   wdata3;

    onchip_memory_bist_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .READ_LATENCY(L)) dut (
        .clk(clk), .reset(rst), .start(start), .mode(mode_i), .seed(seed_i),
        .busy(busy), .done(done), .pass(pass), .err_count(errc), .first_err_addr(ferr),
        .avm_address(addr), .avm_byteenable(be), .avm_chipselect(cs), .avm_write(we),
        .avm_writedata(wdata), .avm_clken(clken), .avm_readdata(rdata)
    );

    onchip_memory_bist_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .READ_LATENCY(L3)) dut3 (
        .clk(clk), .reset(rst), .start(start3), .mode(mode3), .seed(seed3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(errc3), .first_err_addr(ferr3),
        .avm_address(addr3), .avm_byteenable(be3), .avm_chipselect(cs3), .avm_write(we3),
        .avm_writedata(wdata3), .avm_clken(clken3), .avm_readdata(32'd0)
    );

    // Slave model for the L=1 instance: registered read, optional per-address corruption.
    logic [31:0] mem  [D];
    logic [31:0] corr [D];
    logic        preload_req;
    logic [31:0] preload_seed;
    logic [31:0] img_seed;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int a = 0; a < D; a++) mem[a] <= preload_seed + 32'(a);
        end else if (cs === 1'b1 && we === 1'b1) begin
            mem[addr[2:0]] <= wdata;
        end
        if (cs === 1'b1 && we === 1'b0) rdata <= mem[addr[2:0]] ^ corr[addr[2:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors, sampled on the falling edge.
    int    t0 = 0, t3 = 0;
    int    done_n = 0, done_at = -1, viol = 0, viol3 = 0;
    logic  prev_wr = 1'b0;
    xfer_t wr_q[$], rd_q[$], wr3_q[$], rd3_q[$];

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0 + 1;
        if (clken !== 1'b1) viol++;
        if (cs === 1'b1) begin
            if (be !== 4'hF) viol++;
        end else if (be !== 4'h0) viol++;
        if (cs === 1'b1 && we === 1'b1) wr_q.push_back('{rel, 32'(addr), wdata});
        if (cs === 1'b1 && we === 1'b0) begin
            rd_q.push_back('{rel, 32'(addr), 32'd0});
            if (prev_wr) viol++;
        end
        prev_wr = (cs === 1'b1 && we === 1'b1);
        if (done === 1'b1) begin
            done_n++;
            done_at = rel;
            if (busy !== 1'b1) viol++;
        end
    end

    always @(negedge clk) begin
        if (clken3 !== 1'b1) viol3++;
        if (cs3 === 1'b1 && be3 !== 4'hF) viol3++;
        if (cs3 === 1'b1 && we3 === 1'b1) wr3_q.push_back('{cyc - t3 + 1, 32'(addr3), wdata3});
        if (cs3 === 1'b1 && we3 === 1'b0) rd3_q.push_back('{cyc - t3 + 1, 32'(addr3), 32'd0});
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] s);
        @(negedge clk);
        preload_seed = s;
        preload_req  = 1'b1;
        @(negedge clk);
        preload_req  = 1'b0;
        img_seed     = s;
    endtask

    // One run on the L=1 instance, checked against the model. A start with
    // mode 01 is pulsed at relative cycle inject_at; a negative value means no pulse.
    task automatic run_main(input logic [1:0] m, input logic [31:0] s, input int inject_at);
        int          wb, rb, db, vb, rel, exp_done, errs, first, base;
        bit          got;
        logic [31:0] img, rbk;
        wb = wr_q.size(); rb = rd_q.size(); db = done_n; vb = viol;
        @(negedge clk);
        mode_i = m; seed_i = s; start = 1'b1; t0 = cyc + 1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            start = 1'b0;
            rel = cyc - t0 + 1;
            if (rel == inject_at) begin
                start  = 1'b1;
                mode_i = 2'b01;
            end
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 96'(got), 96'd1);
        @(negedge clk);
        chk("busy_after_done", 96'(busy), 96'd0);

        exp_done = (m == 2'b00) ? D + 1 : (m == 2'b01) ? D + L + 1 : 2 * D + L + 2;
        if (m != 2'b01) begin
            chk("wr_count", 96'(wr_q.size() - wb), 96'(D));
            for (int i = 0; i < D && wb + i < wr_q.size(); i++)
                chk("wr_xfer", {32'(wr_q[wb+i].cyc), wr_q[wb+i].addr, wr_q[wb+i].data},
                    {32'(i + 1), 32'(i), s + 32'(i)});
        end else begin
            chk("wr_count", 96'(wr_q.size() - wb), 96'd0);
        end
        if (m != 2'b00) begin
            base = (m == 2'b01) ? 1 : D + 2;
            chk("rd_count", 96'(rd_q.size() - rb), 96'(D));
            for (int i = 0; i < D && rb + i < rd_q.size(); i++)
                chk("rd_xfer", {32'(rd_q[rb+i].cyc), rd_q[rb+i].addr},
                    {32'(base + i), 32'(i)});
        end else begin
            chk("rd_count", 96'(rd_q.size() - rb), 96'd0);
        end

        errs = 0; first = 0;
        img  = (m == 2'b10) ? s : img_seed;
        if (m != 2'b00) begin
            for (int a = 0; a < D; a++) begin
                rbk = (img + 32'(a)) ^ corr[a];
                if (rbk != s + 32'(a)) begin
                    if (errs == 0) first = a;
                    errs++;
                end
            end
        end
        chk("done_pulses", 96'(done_n - db), 96'd1);
        chk("done_cycle", 96'(done_at), 96'(exp_done));
        chk("pass", 96'(pass), 96'((m != 2'b00) && (errs == 0)));
        chk("err_count", 96'(errc), 96'(errs));
        chk("first_err_addr", 96'(ferr), 96'(first));
        chk("bus_protocol", 96'(viol - vb), 96'd0);
        if (m != 2'b01) img_seed = s;
    endtask

    initial begin
        int          wb, rb, db, d3, errs, first;
        bit          got;
        logic [1:0]  m;
        logic [31:0] s;

        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        mode_i = '0; seed_i = '0; mode3 = '0; seed3 = '0;
        preload_req = 1'b0; preload_seed = '0; img_seed = '0;
        for (int a = 0; a < D; a++) corr[a] = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_done", 96'(done), 96'd0);
        chk("rst_pass", 96'(pass), 96'd0);
        chk("rst_cs", 96'(cs), 96'd0);
        chk("rst_write", 96'(we), 96'd0);
        chk("rst_err", 96'(errc), 96'd0);
        chk("rst_first", 96'(ferr), 96'd0);
        chk("rst_addr", 96'(addr), 96'd0);
        chk("rst_be", 96'(be), 96'd0);
        chk("rst_wdata", 96'(wdata), 96'd0);
        chk("rst_clken", 96'(clken), 96'd1);
        rst = 1'b0;
        @(negedge clk);

        // Fill only.
        run_main(2'b00, 32'h0000_0100, -1);

        // Verify against a preloaded image.
        preload(32'hCAFE_0000);
        run_main(2'b01, 32'hCAFE_0000, -1);

        // Fill then verify with address 5 corrupted on readback.
        corr[5] = 32'h0000_0010;
        run_main(2'b10, 32'h5A5A_0000, -1);
        corr[5] = '0;

        // Reserved mode while idle: nothing moves, results hold.
        wb = wr_q.size(); rb = rd_q.size(); db = done_n;
        @(negedge clk);
        mode_i = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("m11_busy", 96'(busy), 96'd0);
        chk("m11_xfers", 96'((wr_q.size() - wb) + (rd_q.size() - rb)), 96'd0);
        chk("m11_done", 96'(done_n - db), 96'd0);
        chk("m11_err_hold", 96'(errc), 96'd1);
        chk("m11_first_hold", 96'(ferr), 96'd5);
        chk("m11_pass_hold", 96'(pass), 96'd0);

        // Wrapping pattern, with a start pulse while busy.
        run_main(2'b00, 32'hFFFF_FFFE, 4);
        if (wr_q.size() >= 8) chk("wrap_addr3", 96'(wr_q[wr_q.size() - 8 + 3].data), 96'h1);

        // Reset in cycle 3 of a fill.
        db = done_n;
        @(negedge clk);
        mode_i = 2'b00; seed_i = 32'h77; start = 1'b1; t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cs_before_reset", 96'(cs), 96'd1);
        rst = 1'b1;
        #1;
        chk("reset_cs", 96'(cs), 96'd0);
        chk("reset_write", 96'(we), 96'd0);
        chk("reset_busy", 96'(busy), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (D + 5) @(negedge clk);
        chk("reset_no_done", 96'(done_n - db), 96'd0);
        run_main(2'b00, 32'h0000_0033, -1);

        // L=3 instance against an all-zero slave.
        wb = wr3_q.size(); rb = rd3_q.size();
        @(negedge clk);
        mode3 = 2'b01; seed3 = 32'd0; start3 = 1'b1; t3 = cyc + 1;
        got = 1'b0; d3 = -1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (done3 === 1'b1) begin
                got = 1'b1;
                d3  = cyc - t3 + 1;
            end
        end
        start3 = 1'b0;
        chk("l3_done_seen", 96'(got), 96'd1);
        @(negedge clk);
        chk("l3_busy_after", 96'(busy3), 96'd0);
        errs = 0; first = 0;
        for (int a = 0; a < D; a++) begin
            if (32'd0 != seed3 + 32'(a)) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
        chk("l3_done_cycle", 96'(d3), 96'(D + L3 + 1));
        chk("l3_err_count", 96'(errc3), 96'(errs));
        chk("l3_first_err", 96'(ferr3), 96'(first));
        chk("l3_pass", 96'(pass3), 96'd0);
        chk("l3_no_writes", 96'(wr3_q.size() - wb), 96'd0);
        chk("l3_rd_count", 96'(rd3_q.size() - rb), 96'(D));
        for (int i = 0; i < D && rb + i < rd3_q.size(); i++)
            chk("l3_rd_xfer", {32'(rd3_q[rb+i].cyc), rd3_q[rb+i].addr}, {32'(i + 1), 32'(i)});
        chk("l3_protocol", 96'(viol3), 96'd0);

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            m = 2'($urandom_range(0, 2));
            s = $urandom;
            if (m == 2'b01) begin
                if ($urandom_range(0, 3) == 0) preload($urandom);
                else preload(s);
            end
            for (int a = 0; a < D; a++)
                corr[a] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : 32'd0;
            run_main(m, s, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_memory_bist_master.md
# onchip_memory_bist_master

Avalon-MM initiator that drives the single-port on-chip memory's s1 slave to fill it with a deterministic pattern and/or read it back and check it. It sits beside the Nios II data master in the system, connected to the memory slave through the interconnect, and is controlled by a simple start/mode interface from a CSR block. It serves as the power-on memory self-test and as a hardware cross-check of the initialisation image path.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 13, word-address width
- DEPTH, 5120, words tested; covers addresses 0..DEPTH-1; must satisfy DEPTH ≤ 2^ADDR_WIDTH
- READ_LATENCY, 1, slave read latency in cycles; legal range 1..3

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- mode  in  2  00 fill, 01 verify, 10 fill-then-verify, 11 reserved
- seed  in  DATA_WIDTH  pattern base
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- pass  out  1  last run had zero mismatches; verify modes only
- err_count  out  16  mismatch count, saturating
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch
- avm_address  out  ADDR_WIDTH  word address
- avm_byteenable  out  DATA_WIDTH/8  all ones while chipselect is high, else 0
- avm_chipselect  out  1  transfer valid
- avm_write  out  1  1 = write, 0 = read
- avm_writedata  out  DATA_WIDTH  write data
- avm_clken  out  1  held constant 1
- avm_readdata  in  DATA_WIDTH  valid READ_LATENCY cycles after the read is issued

## Operation
- Reset values:
  - busy, done, pass, avm_chipselect, avm_write = 0
  - err_count, first_err_addr, avm_address, avm_byteenable, avm_writedata = 0
  - avm_clken = 1
  - state = IDLE
- Pattern: word at address a = seed + zero-extended a, taken modulo 2^DATA_WIDTH (wraps).
- States: IDLE, FILL, GAP, VERIFY, DRAIN, DONE.
- From IDLE, start=1:
  - mode 00 → FILL
  - mode 01 → VERIFY
  - mode 10 → FILL
  - mode 11 → stay in IDLE, no output change
- On entry from IDLE: err_count, first_err_addr and pass are cleared.
- FILL:
  - One write per cycle: chipselect=1, write=1, address = a, writedata = pattern(a), for a = 0..DEPTH-1.
  - After a = DEPTH-1: → GAP if mode 10, else → DONE.
- GAP: one idle cycle with chipselect=0, then → VERIFY.
- VERIFY:
  - One read per cycle: chipselect=1, write=0, a = 0..DEPTH-1.
  - The expected word and address travel through a READ_LATENCY-deep pipeline alongside each read.
  - After the last issue → DRAIN.
- DRAIN: chipselect=0 for READ_LATENCY cycles while outstanding compares retire, then → DONE.
- Compare: in each cycle where a tagged read returns, avm_readdata ≠ expected is a mismatch.
  - err_count increments, saturating at 0xFFFF.
  - On the first mismatch of the run, first_err_addr latches that read's address.
- DONE:
  - done=1 and busy=1 for one cycle, then → IDLE.
  - pass = (err_count==0) for modes 01 and 10; pass = 0 for mode 00.
- Outputs hold until the next accepted start.
- start while busy is ignored.
- Reset asserted mid-run: chipselect, write and busy drop asynchronously, the state returns to IDLE, and no done pulse is produced.

## Timing
Cycle 0 is the edge that samples start; D = DEPTH, L = READ_LATENCY.
- Mode 00: writes in cycles 1..D; done in cycle D+1; busy low from cycle D+2.
- Mode 01: reads in cycles 1..D; last compare in cycle D+L; done in cycle D+L+1.
- Mode 10: writes in cycles 1..D; GAP in cycle D+1; reads in cycles D+2..2D+1; done in cycle 2D+L+2.
- Throughput is one transfer per cycle; the slave has no waitrequest.
- A write and a read are never issued back-to-back; GAP separates them.

## Test plan
- DEPTH=8, mode 00, seed=0x100 → writes to addresses 0..7 with data 0x100..0x107 in cycles 1..8; done in cycle 9; pass=0.
- DEPTH=8, L=1, memory model preloaded with the seed pattern, mode 01 → done in cycle 10, pass=1, err_count=0, first_err_addr=0.
- Mode 10 with the model corrupting address 5 after the fill → err_count=1, first_err_addr=5, pass=0, done in cycle 19.
- seed=0xFFFFFFFE, mode 00 → address 3 written with 0x00000001 (wrap); a second start during busy, and a start with mode 11 while idle, are both ignored.
- Reset asserted in cycle 3 of a fill → chipselect and busy go to 0 in the same cycle, no done pulse; a following start runs cleanly from address 0.
- L=3, a memory model returning all-zeros, mode 01, DEPTH=8, seed=0 → err_count=7, first_err_addr=1, done in cycle 12.
